// File: rtl/sprinkler_pkg.sv
// Shared types and helpers for the sprinkler zone sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, zone count/width, lowest-set-bit zone search.
package sprinkler_pkg;

  localparam int NUM_ZONES = 8;
  localparam int ZONE_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WATER,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic              found;
    logic [ZONE_W-1:0] zone;
  } zone_pick_t;

  // Lowest set mask bit with index >= lo. Scanning downwards lets the
  // lowest qualifying index win. A lo past the top zone yields found=0,
  // so there is no wrap past zone 7.
  function automatic zone_pick_t lowest_from(input logic [NUM_ZONES-1:0] mask,
                                             input int lo);
    zone_pick_t pick;
    pick.found = 1'b0;
    pick.zone  = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) begin
        pick.found = 1'b1;
        pick.zone  = ZONE_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sprinkler_zone_sequencer_tick_prescaler.sv
// Purpose: divides clk into a 1-cycle tick pulse every TICK_DIV cycles while run=1.
// Latency: first tick TICK_DIV run-cycles after clr; tick is combinational from the count.
// Backpressure: run=0 freezes the count; clr has priority and restarts a full period.
// Ports: clk, rst_n (sync, active-low), clr, run -> tick.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Deliberately independent of clr: clr is derived from the FSM next
  // state, which itself depends on tick.
  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/sprinkler_zone_sequencer.sv
// Purpose: walks zones 0..7 once per start, opening each zone set in zone_mask for dwell ticks,
//          with GAP_TICKS closed-valve ticks between zones; drives decoder E and select A,B,C.
// Latency: start sampled in cycle n -> busy/SELECT in n+1, E=1 in n+2; E high dwell*TICK_DIV clks.
// Backpressure: none; start ignored while busy, abort wins over everything and returns to IDLE.
// Ports: clk, rst_n (sync, active-low), start, abort, zone_mask[7:0], dwell[DWELL_W-1:0]
//        -> E, A, B, C, cur_zone[2:0], busy, done. All outputs come straight from registers.
// Option: define RAIN_SENSOR_EN to add input rain; rain=1 during WATER closes the valve and
//         freezes the tick and dwell counts. Without it the design behaves as if rain were 0.
// GAP_TICKS must be at least 1.
module sprinkler_zone_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DWELL_W   = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
`ifdef RAIN_SENSOR_EN
  input  logic                            rain,
`endif
  input  logic [sprinkler_pkg::NUM_ZONES-1:0] zone_mask,
  input  logic [DWELL_W-1:0]              dwell,
  output logic                            E,
  output logic                            A,
  output logic                            B,
  output logic                            C,
  output logic [sprinkler_pkg::ZONE_W-1:0] cur_zone,
  output logic                            busy,
  output logic                            done
);

  import sprinkler_pkg::*;

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

`ifndef RAIN_SENSOR_EN
  logic rain;
  assign rain = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [ZONE_W-1:0]      zone_q, zone_d;
  logic                   e_q, e_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_ZONES-1:0]   mask_q, mask_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;
  logic [DWELL_W-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

  logic       tick;
  logic       presc_clr;
  logic       presc_run;
  zone_pick_t first_pick;
  zone_pick_t next_pick;

  // First zone comes from the live mask (it is latched the same edge);
  // later zones come from the latched copy, strictly above the current one.
  assign first_pick = lowest_from(zone_mask, 0);
  assign next_pick  = lowest_from(mask_q, int'(zone_q) + 1);

  // Prescaler only runs in the two timed states. Clearing on every state
  // change makes the first tick of each WATER/GAP a full period.
  assign presc_run = ((state_q == WATER) && !rain) || (state_q == GAP);
  assign presc_clr = ((state_q != WATER) && (state_q != GAP)) || (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .run   (presc_run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      zone_q      <= '0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      zone_q      <= zone_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    zone_d      = zone_q;
    e_d         = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d = zone_mask;
          dwell_d = dwell;
          busy_d = 1'b1;
          // Nothing to water: finish without ever powering a valve.
          if ((zone_mask == '0) || (dwell == '0)) begin
            state_d = DONE;
          end else begin
            zone_d  = first_pick.zone;
            state_d = SELECT;
          end
        end
      end

      SELECT: begin
        // Address has had this cycle to settle; power the valve next.
        state_d     = WATER;
        e_d         = 1'b1;
        dwell_cnt_d = '0;
      end

      WATER: begin
        e_d = !rain;
        if (tick) begin
          if (dwell_cnt_q == dwell_q - DWELL_W'(1)) begin
            e_d         = 1'b0;
            dwell_cnt_d = '0;
            gap_cnt_d   = '0;
            state_d     = next_pick.found ? GAP : DONE;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
      end

      GAP: begin
        // Select keeps the previous zone here; the next zone is loaded on
        // the way into SELECT so the address changes with E already low.
        if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            zone_d    = next_pick.zone;
            gap_cnt_d = '0;
            state_d   = SELECT;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      e_d         = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      dwell_cnt_d = '0;
      gap_cnt_d   = '0;
    end
  end

  assign E         = e_q;
  assign {A, B, C} = zone_q;
  assign cur_zone  = zone_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprinkler_zone_sequencer.sv
// Directed bench for sprinkler_zone_sequencer with TICK_DIV=4, GAP_TICKS=2, DWELL_W=8.
// Expected cycle counts are hand-derived; cycle 1 is the first cycle after start is sampled.
module tb_sprinkler_zone_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] zone_mask;
  logic [7:0] dwell;
  logic       E, A, B, C;
  logic [2:0] cur_zone;
  logic       busy;
  logic       done;
`ifdef RAIN_SENSOR_EN
  logic       rain = 1'b0;
  int         rain_at = 1000;
`endif

  sprinkler_zone_sequencer #(
    .TICK_DIV  (4),
    .DWELL_W   (8),
    .GAP_TICKS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
`ifdef RAIN_SENSOR_EN
    .rain      (rain),
`endif
    .zone_mask (zone_mask),
    .dwell     (dwell),
    .E         (E),
    .A         (A),
    .B         (B),
    .C         (C),
    .cur_zone  (cur_zone),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pass observations
  int         n_runs, e_total, done_cnt, done_cyc, busy_cycles, abc_bad, zone_bad;
  int         run_len[8];
  logic [2:0] run_zone[8];
  int         gap_len[8];
  logic [2:0] fall_zone[8];

  // Watches outputs from cycle 1 until 5 cycles past the first done (or budget).
  task automatic collect(input int budget, input int release_at);
    int   low_len;
    logic prev_e;
    int   r;
    low_len = 0; prev_e = 1'b0;
    n_runs = 0; e_total = 0; done_cnt = 0; done_cyc = -1;
    busy_cycles = 0; abc_bad = 0; zone_bad = 0;
    for (int k = 0; k < 8; k++) begin
      run_len[k] = 0; run_zone[k] = '0; gap_len[k] = 0; fall_zone[k] = '0;
    end
    for (int i = 0; i < budget; i++) begin
      if (i == release_at) start = 1'b0;
`ifdef RAIN_SENSOR_EN
      rain = (i + 1 >= rain_at) && (i + 1 < rain_at + 5);
`endif
      r = (n_runs > 0) ? ((n_runs > 8) ? 7 : n_runs - 1) : 0;
      if ({A, B, C} !== cur_zone) abc_bad++;
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = i + 1;
      end
      if (E) begin
        e_total++;
        if (!prev_e) begin
          if (n_runs < 8) begin
            run_zone[n_runs] = cur_zone;
            run_len[n_runs]  = 1;
            if (n_runs > 0) gap_len[n_runs-1] = low_len;
          end
          n_runs++;
        end else begin
          if (cur_zone !== run_zone[r]) zone_bad++;
          run_len[r]++;
        end
      end else begin
        if (prev_e) begin
          fall_zone[r] = cur_zone;
          low_len = 0;
        end
        low_len++;
      end
      prev_e = E;
      if ((done_cyc >= 0) && (i + 1 >= done_cyc + 5)) break;
      step();
    end
`ifdef RAIN_SENSOR_EN
    rain = 1'b0;
`endif
  endtask

  task automatic launch(input logic [7:0] m, input logic [7:0] d);
    zone_mask = m;
    dwell     = d;
    start     = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; zone_mask = '0; dwell = '0;
    step(); step();
    check("rst_E", E, 0);
    check("rst_abc", {A, B, C}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Reset mid-pass: zone 6 watering in cycle 7.
    launch(8'b0100_0000, 8'd5);
    start = 1'b0;
    repeat (6) step();
    check("pre_rst_E", E, 1);
    check("pre_rst_zone", cur_zone, 6);
    rst_n = 1'b0;
    step();
    check("midrst_E", E, 0);
    check("midrst_abc", {A, B, C}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    check("postrst_busy", busy, 0);

    // Zones 0,2,7 dwell 3: E 12 clks each, 9 low clks between, done in cycle 57.
    launch(8'b1000_0101, 8'd3);
    check("t2_busy_c1", busy, 1);
    check("t2_E_c1", E, 0);
    collect(120, 0);
    check("t2_runs", n_runs, 3);
    check("t2_zone0", run_zone[0], 0);
    check("t2_zone1", run_zone[1], 2);
    check("t2_zone2", run_zone[2], 7);
    check("t2_len0", run_len[0], 12);
    check("t2_len1", run_len[1], 12);
    check("t2_len2", run_len[2], 12);
    check("t2_gap0", gap_len[0], 9);
    check("t2_gap1", gap_len[1], 9);
    check("t2_gap_holds", fall_zone[0], 0);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_cyc", done_cyc, 57);
    check("t2_busy_cyc", busy_cycles, 56);
    check("t2_abc", abc_bad, 0);
    check("t2_zone_stable", zone_bad, 0);
    check("t2_busy_end", busy, 0);

    // Empty mask, then zero dwell: immediate done.
    launch(8'h00, 8'd5);
    collect(20, 0);
    check("t3a_runs", n_runs, 0);
    check("t3a_done_cyc", done_cyc, 2);
    check("t3a_busy_cyc", busy_cycles, 1);
    check("t3a_done_cnt", done_cnt, 1);
    launch(8'h01, 8'd0);
    collect(20, 0);
    check("t3b_runs", n_runs, 0);
    check("t3b_done_cyc", done_cyc, 2);
    check("t3b_busy_cyc", busy_cycles, 1);

    // Abort in IDLE together with start: nothing happens.
    zone_mask = 8'hFF; dwell = 8'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    step();
    check("idle_abort_done", done, 0);
    check("idle_abort_E", E, 0);

    // Abort during zone 3 WATER.
    launch(8'hFF, 8'd2);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (E && (cur_zone == 3'd3)) begin
        hit = 1;
        break;
      end
      step();
    end
    check("t4_reach_z3", hit, 1);
    repeat (3) step();
    check("t4_E_before", E, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_E", E, 0);
    check("t4_abort_busy", busy, 0);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || E) hit++;
      step();
    end
    check("t4_quiet", hit, 0);
    launch(8'h10, 8'd1);
    collect(40, 0);
    check("t4_re_runs", n_runs, 1);
    check("t4_re_zone", run_zone[0], 4);
    check("t4_re_len", run_len[0], 4);
    check("t4_re_done_cyc", done_cyc, 7);
    check("t4_re_done_cnt", done_cnt, 1);

    // Start and mask/dwell changes while busy are ignored.
    launch(8'h01, 8'd2);
    zone_mask = 8'h02; dwell = 8'd7; start = 1'b1;
    collect(60, 4);
    check("t5_runs", n_runs, 1);
    check("t5_zone", run_zone[0], 0);
    check("t5_len", run_len[0], 8);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_done_cyc", done_cyc, 11);
    check("t5_busy_cyc", busy_cycles, 10);

`ifdef RAIN_SENSOR_EN
    // Rain cycles 5..9: E low 6..10, still 12 clks total, done 5 clks late.
    rain_at = 5;
    launch(8'h01, 8'd3);
    collect(60, 0);
    rain_at = 1000;
    check("t6_e_total", e_total, 12);
    check("t6_runs", n_runs, 2);
    check("t6_gap", gap_len[0], 5);
    check("t6_done_cyc", done_cyc, 20);
    check("t6_done_cnt", done_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
